// File: rtl/acq_readout.sv
// Chronological readback of the circular acquisition buffer: one word is read at a time,
// starting at the pivot and wrapping at DEPTH, and each word is handed to a valid/ready stream.
module acq_readout #(
   parameter int ADDR_WIDTH = 23,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 22,
   parameter int DEPTH      = 4194304,
   parameter int BASE       = 0
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [IDX_WIDTH-1:0]  pivot,
   input  logic [IDX_WIDTH:0]    count,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_rd_req,
   output logic [ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                  mem_rd_ack,
   input  logic                  mem_rd_valid,
   input  logic [DATA_WIDTH-1:0] mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last
);

   localparam logic [IDX_WIDTH:0]    DEPTH_C  = (IDX_WIDTH+1)'(DEPTH);
   localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH-1:0] BASE_C   = ADDR_WIDTH'(BASE);
   localparam logic [IDX_WIDTH:0]    REM_ONE  = (IDX_WIDTH+1)'(1);
   localparam logic [IDX_WIDTH-1:0]  IDX_ONE  = IDX_WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;

   state_t                state_q, state_d;
   logic [IDX_WIDTH-1:0]  idx_q, idx_d;
   logic [IDX_WIDTH:0]    rem_q, rem_d;
   logic                  abort_pend_q, abort_pend_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_last_q, out_last_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         rem_q        <= '0;
         abort_pend_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         rem_q        <= rem_d;
         abort_pend_q <= abort_pend_d;
         done_q       <= done_d;
         err_q        <= err_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_data_q   <= out_data_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      rem_d        = rem_q;
      abort_pend_d = abort_pend_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_data_d   = out_data_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (({1'b0, pivot} >= DEPTH_C) || (count > DEPTH_C)) begin
                  err_d = 1'b1;
               end else if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  idx_d        = pivot;
                  rem_d        = count;
                  abort_pend_d = 1'b0;
                  state_d      = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Once acked the read is in flight; an abort must wait for its data.
            if (mem_rd_ack) begin
               abort_pend_d = abort;
               state_d      = S_WAIT;
            end else if (abort) begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (abort) abort_pend_d = 1'b1;
            if (mem_rd_valid) begin
               abort_pend_d = 1'b0;
               if (abort_pend_q || abort) begin
                  state_d = S_IDLE;
               end else begin
                  out_data_d  = mem_rd_data;
                  out_valid_d = 1'b1;
                  out_last_d  = (rem_q == REM_ONE);
                  state_d     = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (abort) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               state_d     = S_IDLE;
            end else if (out_ready) begin
               rem_d       = rem_q - REM_ONE;
               idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_ONE;
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               if (out_last_q) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy        = (state_q != S_IDLE);
   assign done        = done_q;
   assign err         = err_q;
   assign mem_rd_req  = (state_q == S_REQ);
   assign mem_rd_addr = (state_q == S_REQ) ? (BASE_C + ADDR_WIDTH'(idx_q)) : '0;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;
   assign out_last    = out_last_q;

endmodule

// File: tb/tb_acq_readout.sv
// Bench for acq_readout: memory model returns data = address; readouts are checked
// against the expected chronological sequence (pivot + k) mod DEPTH.
module tb_acq_readout;
   localparam int AW = 12, DW = 16, IW = 4, DEPTH = 8, BASE = 100;

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
   logic [IW-1:0] pivot = '0;
   logic [IW:0]   count = '0;
   logic          busy, done, err, mem_rd_req, out_valid, out_last;
   logic          mem_rd_ack = 1'b0, mem_rd_valid = 1'b0, out_ready = 1'b0;
   logic [AW-1:0] mem_rd_addr;
   logic [DW-1:0] mem_rd_data = '0, out_data;

   always #5 clk = ~clk;

   acq_readout #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .DEPTH(DEPTH), .BASE(BASE)) dut (
      .sys_clk(clk), .sys_rst(rst), .start(start), .abort(abort), .pivot(pivot), .count(count),
      .busy(busy), .done(done), .err(err), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
      .mem_rd_ack(mem_rd_ack), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last));

   // Memory controller model: ack after ack_lat extra cycles, data dat_lat cycles after the ack.
   int            ack_lat = 0, dat_lat = 1, req_wait = 0, lat_cnt = 0;
   logic          pend = 1'b0, inject = 1'b0;
   logic [AW-1:0] pend_addr = '0;

   always @(posedge clk) begin
      mem_rd_ack   <= 1'b0;
      mem_rd_valid <= 1'b0;
      if (mem_rd_req && !mem_rd_ack) begin
         if (req_wait >= ack_lat) begin
            mem_rd_ack <= 1'b1;
            pend       <= 1'b1;
            pend_addr  <= mem_rd_addr;
            lat_cnt    <= dat_lat;
            req_wait   <= 0;
         end else req_wait <= req_wait + 1;
      end else if (!mem_rd_req) req_wait <= 0;
      if (pend) begin
         if (lat_cnt == 0) begin
            mem_rd_valid <= 1'b1;
            mem_rd_data  <= DW'(pend_addr);
            pend         <= 1'b0;
         end else lat_cnt <= lat_cnt - 1;
      end
      if (inject) begin
         mem_rd_valid <= 1'b1;
         mem_rd_data  <= 16'hDEAD;
      end
   end

   int n_chk = 0, n_fail = 0;
   int n_done, n_err, n_ov, n_viol, n_req, n_busy;
   int ready_mode = 0, hold_at = -1, hold_left = 0;
   logic held;
   logic          prev_ov, prev_hs, prev_req, prev_ack, prev_last;
   logic [DW-1:0] prev_data;
   logic [AW-1:0] prev_addr;
   logic [DW-1:0] got_d[$];
   logic          got_l[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic clr();
      n_done = 0; n_err = 0; n_ov = 0; n_viol = 0; n_req = 0; n_busy = 0;
      prev_ov = 0; prev_hs = 0; prev_req = 0; prev_ack = 0; prev_last = 0;
      prev_data = '0; prev_addr = '0; held = 0; hold_left = 0; hold_at = -1;
      got_d.delete(); got_l.delete();
   endtask

   // One cycle: observe outputs at the falling edge, then drive out_ready for the next rising edge.
   task automatic step();
      logic hs;
      @(negedge clk);
      if (done) n_done++;
      if (err) n_err++;
      if (busy) n_busy++;
      if (mem_rd_req) n_req++;
      if (out_valid) n_ov++;
      if (done && err) n_viol++;
      if (mem_rd_req && out_valid) n_viol++;
      if (out_valid && prev_ov && !prev_hs && (out_data !== prev_data || out_last !== prev_last)) n_viol++;
      if (mem_rd_req && prev_req && !prev_ack && mem_rd_addr !== prev_addr) n_viol++;
      if (ready_mode == 1) out_ready = 1'b0;
      else if (hold_left > 0) begin out_ready = 1'b0; hold_left--; end
      else if (hold_at >= 0 && !held && out_valid && got_d.size() == hold_at) begin
         out_ready = 1'b0; held = 1; hold_left = 9;
      end else out_ready = ($urandom_range(0, 3) != 0);
      hs = out_valid && out_ready;
      if (hs) begin got_d.push_back(out_data); got_l.push_back(out_last); end
      prev_ov = out_valid; prev_hs = hs; prev_req = mem_rd_req; prev_ack = mem_rd_ack;
      prev_data = out_data; prev_last = out_last; prev_addr = mem_rd_addr;
   endtask

   task automatic run_read(input int pv, input int cn, input int hold_idx);
      logic ok;
      int   n_exp;
      clr();
      hold_at = hold_idx;
      start = 1'b1; pivot = IW'(pv); count = (IW+1)'(cn);
      step();
      start = 1'b0;
      for (int c = 0; c < 3000 && busy; c++) step();
      chk("idle_at_end", busy, 0);
      ok = (pv < DEPTH) && (cn <= DEPTH);
      n_exp = ok ? cn : 0;
      if (!ok) begin
         chk("err_pulse", n_err, 1);
         chk("no_done_on_err", n_done, 0);
         chk("busy_on_err", n_busy, 0);
      end else begin
         chk("no_err", n_err, 0);
         chk("done_pulses", n_done, 1);
         chk("done_with_busy_fall", done, 1);
      end
      if (n_exp == 0) chk("no_mem_req", n_req, 0);
      chk("word_count", got_d.size(), n_exp);
      for (int k = 0; k < n_exp && k < got_d.size(); k++) begin
         chk("word_data", got_d[k], BASE + ((pv + k) % DEPTH));
         chk("word_last", got_l[k], (k == n_exp - 1) ? 1 : 0);
      end
      chk("protocol", n_viol, 0);
      step(); step();
   endtask

   initial begin
      clr();
      repeat (3) step();
      chk("rst_ctl", {busy, done, err, mem_rd_req, out_valid, out_last}, 0);
      chk("rst_addr", mem_rd_addr, 0);
      chk("rst_data", out_data, 0);
      rst = 1'b0;
      step();

      ack_lat = 0; dat_lat = 1;
      run_read(5, 8, -1);      // full wrap from pivot 5
      run_read(0, 3, -1);      // addresses BASE..BASE+2
      run_read(1, 4, 1);       // back-pressure on word 2
      run_read(7, 8, -1);      // wrap immediately
      run_read(3, 0, -1);      // empty readout
      run_read(8, 4, -1);      // pivot out of range
      run_read(2, 9, -1);      // count out of range
      run_read(0, 1, -1);

      // abort while waiting for data
      clr(); ack_lat = 0; dat_lat = 4;
      start = 1'b1; pivot = 4'd2; count = 5'd4; step(); start = 1'b0;
      for (int c = 0; c < 30 && !(mem_rd_req && mem_rd_ack); c++) step();
      chk("abort_wait_acked", mem_rd_ack, 1);
      step();
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_wait_busy", busy, 1);
      for (int c = 0; c < 30 && busy; c++) step();
      chk("abort_wait_idle", busy, 0);
      chk("abort_wait_no_out", n_ov, 0);
      chk("abort_wait_no_done", n_done, 0);
      repeat (3) step();

      // abort while requesting (no ack yet)
      clr(); ack_lat = 3; dat_lat = 1;
      start = 1'b1; pivot = 4'd6; count = 5'd2; step(); start = 1'b0;
      chk("abort_req_in_req", mem_rd_req, 1);
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_req_idle", busy, 0);
      chk("abort_req_drop", mem_rd_req, 0);
      repeat (3) step();
      chk("abort_req_no_done", n_done, 0);
      chk("abort_req_no_out", n_ov, 0);

      // reset while holding a word in OUT
      clr(); ack_lat = 0; dat_lat = 1; ready_mode = 1;
      start = 1'b1; pivot = 4'd2; count = 5'd4; step(); start = 1'b0;
      for (int c = 0; c < 50 && !out_valid; c++) step();
      chk("rst_reached_out", out_valid, 1);
      rst = 1'b1; step();
      chk("rst_mid_ctl", {busy, done, err, mem_rd_req, out_valid, out_last}, 0);
      chk("rst_mid_addr", mem_rd_addr, 0);
      chk("rst_mid_data", out_data, 0);
      rst = 1'b0; n_ov = 0;
      inject = 1'b1; step(); inject = 1'b0;
      repeat (4) step();
      chk("stray_valid_ignored", n_ov, 0);
      chk("stray_valid_idle", busy, 0);
      ready_mode = 0;

      for (int r = 0; r < 40; r++) begin
         ack_lat = $urandom_range(0, 2);
         dat_lat = $urandom_range(0, 3);
         run_read($urandom_range(0, 9), $urandom_range(0, 10), ($urandom_range(0, 3) == 0) ? 0 : -1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/acq_readout.md
Name: acq_readout

Overview:
- Read-side counterpart to the acquisition writer, which fills a circular sample buffer in external PSRAM and stops with a pivot index.
- After acquisition ends, this block reads the buffer back in chronological order: it starts at the pivot (the oldest sample) and wraps at DEPTH.
- It issues single-word read requests to the memory controller and delivers the returned words on a valid/ready stream to the host link (UART/FIFO).
- At most one read is outstanding at any time; the output register doubles as the holding buffer.

Parameters:
- ADDR_WIDTH, 23, memory word-address width.
- DATA_WIDTH, 16, memory/sample word width.
- IDX_WIDTH, 22, buffer index width; equals the pivot width.
- DEPTH, 4194304, buffer length in words; any value from 2 to 2^IDX_WIDTH, not necessarily a power of two.
- BASE, 0, word address of buffer index 0; BASE+DEPTH-1 must fit in ADDR_WIDTH.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset; synchronous, active-high.
- start  in  1  single-cycle request to begin readout; sampled only in IDLE.
- abort  in  1  level; cancels the readout in progress.
- pivot  in  IDX_WIDTH  index of the oldest sample; latched on start.
- count  in  IDX_WIDTH+1  number of words to read (0..DEPTH); latched on start.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when readout completes (including count=0).
- err  out  1  one-cycle pulse when start is rejected.
- mem_rd_req  out  1  read request; held until mem_rd_ack.
- mem_rd_addr  out  ADDR_WIDTH  read word address; stable while mem_rd_req is high.
- mem_rd_ack  in  1  controller accepted the request.
- mem_rd_valid  in  1  read data valid; one pulse per accepted request, at least 1 cycle after the ack.
- mem_rd_data  in  DATA_WIDTH  read data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  DATA_WIDTH  sample word.
- out_last  out  1  high with the final word of a readout.

Behaviour:
- Reset (sys_rst=1 at an edge) overrides everything: state=IDLE; busy, done, err, mem_rd_req, out_valid, out_last = 0; mem_rd_addr, out_data = 0. Applies mid-operation; a later mem_rd_valid from the controller is ignored in IDLE.
- Internal registers: idx (IDX_WIDTH), rem (IDX_WIDTH+1), abort_pend (1).
- IDLE, on start:
  - pivot>=DEPTH or count>DEPTH: err=1 next cycle; stay IDLE.
  - count==0: done=1 next cycle; stay IDLE.
  - otherwise: idx<=pivot, rem<=count, go to REQ. mem_rd_req is high on the cycle after start (1-cycle latency).
- REQ: mem_rd_req=1, mem_rd_addr=BASE+idx.
  - mem_rd_ack: go to WAIT; mem_rd_req drops the next cycle.
  - abort with no ack that cycle: go to IDLE; no done.
  - abort and ack in the same cycle: treat as the WAIT case below.
- WAIT: waits for mem_rd_valid.
  - An abort seen here sets abort_pend.
  - On mem_rd_valid with abort_pend (or abort) set: discard the data, clear abort_pend, go to IDLE.
  - On mem_rd_valid otherwise: out_data<=mem_rd_data, out_valid<=1, out_last<=(rem==1), go to OUT.
- OUT: out_valid, out_data and out_last held stable until out_ready.
  - abort: out_valid drops, go to IDLE; the word is not delivered.
  - out_ready (valid&ready handshake):
    - rem<=rem-1.
    - idx<=(idx==DEPTH-1) ? 0 : idx+1 (compare-and-reset; no modulo operator).
    - out_valid<=0.
    - If out_last: done=1 next cycle, go to IDLE; else go to REQ.
- Throughput: at most 1 word per (ack latency + data latency + 2) cycles. No pipelining is required.
- start outside IDLE is ignored. done and err never assert together.
- Address arithmetic: mem_rd_addr = BASE + zero-extended idx, computed in ADDR_WIDTH bits.

Test Plan:
- DEPTH=8, pivot=5, count=8; memory model with 1-cycle ack and 2-cycle data returning data=addr -> out_data sequence 5,6,7,0,1,2,3,4; out_last only on the 4; one done pulse; busy falls the same cycle done rises.
- DEPTH=8, BASE=100, pivot=0, count=3 -> mem_rd_addr 100,101,102; out_last on the third word.
- out_ready held low for 10 cycles on word 2 of a count=4 run -> out_data stable, mem_rd_req stays low throughout, no word lost or duplicated.
- start with count=0 -> done pulse, no mem_rd_req. start with pivot=8 on DEPTH=8 -> err pulse, busy stays 0.
- abort asserted during WAIT -> returned data discarded, no out_valid, IDLE after mem_rd_valid, no done. abort during REQ -> IDLE next cycle.
- sys_rst pulsed while in OUT -> next cycle all outputs 0; a stray mem_rd_valid afterwards produces no out_valid.
